// File: rtl/sram_arb_2p.sv
// Round-robin arbiter sharing one single-port byte-enabled SRAM between an
// instruction-fetch port (0) and a load/store port (1) on a req/gnt/rvalid handshake.
module sram_arb_2p #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req_i,
  input  logic [ADDR_WIDTH+1:0] p0_addr_i,
  input  logic                  p0_we_i,
  input  logic [BE_WIDTH-1:0]   p0_be_i,
  input  logic [DATA_WIDTH-1:0] p0_wdata_i,
  output logic                  p0_gnt_o,
  output logic                  p0_rvalid_o,
  output logic [DATA_WIDTH-1:0] p0_rdata_o,
  input  logic                  p1_req_i,
  input  logic [ADDR_WIDTH+1:0] p1_addr_i,
  input  logic                  p1_we_i,
  input  logic [BE_WIDTH-1:0]   p1_be_i,
  input  logic [DATA_WIDTH-1:0] p1_wdata_i,
  output logic                  p1_gnt_o,
  output logic                  p1_rvalid_o,
  output logic [DATA_WIDTH-1:0] p1_rdata_o,
  output logic                  sram_cen_n_o,
  output logic                  sram_gwen_n_o,
  output logic [BE_WIDTH-1:0]   sram_ben_n_o,
  output logic [ADDR_WIDTH-1:0] sram_a_o,
  output logic [DATA_WIDTH-1:0] sram_d_o,
  input  logic [DATA_WIDTH-1:0] sram_q_i
);

  logic last_gnt_q, last_gnt_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_owner_q, rsp_owner_d;
  logic gnt0, gnt1;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{p0_addr_i[1:0], p1_addr_i[1:0]};

  // On contention the port that did not win last time gets the grant.
  assign gnt0 = p0_req_i & (~p1_req_i | last_gnt_q);
  assign gnt1 = p1_req_i & (~p0_req_i | ~last_gnt_q);

  assign p0_gnt_o = gnt0;
  assign p1_gnt_o = gnt1;

  always_comb begin
    sram_cen_n_o  = 1'b1;
    sram_gwen_n_o = 1'b1;
    sram_ben_n_o  = '1;
    sram_a_o      = '0;
    sram_d_o      = '0;
    last_gnt_d    = last_gnt_q;
    rsp_valid_d   = gnt0 | gnt1;
    rsp_owner_d   = rsp_owner_q;
    if (gnt0) begin
      sram_cen_n_o  = 1'b0;
      sram_gwen_n_o = ~p0_we_i;
      sram_ben_n_o  = p0_we_i ? ~p0_be_i : '1;
      sram_a_o      = p0_addr_i[ADDR_WIDTH+1:2];
      sram_d_o      = p0_wdata_i;
      last_gnt_d    = 1'b0;
      rsp_owner_d   = 1'b0;
    end else if (gnt1) begin
      sram_cen_n_o  = 1'b0;
      sram_gwen_n_o = ~p1_we_i;
      sram_ben_n_o  = p1_we_i ? ~p1_be_i : '1;
      sram_a_o      = p1_addr_i[ADDR_WIDTH+1:2];
      sram_d_o      = p1_wdata_i;
      last_gnt_d    = 1'b1;
      rsp_owner_d   = 1'b1;
    end
  end

  // last_gnt resets to 1 so port 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q  <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
    end
  end

  assign p0_rvalid_o = rsp_valid_q & ~rsp_owner_q;
  assign p1_rvalid_o = rsp_valid_q & rsp_owner_q;
  assign p0_rdata_o  = p0_rvalid_o ? sram_q_i : '0;
  assign p1_rdata_o  = p1_rvalid_o ? sram_q_i : '0;

endmodule

// File: tb/tb_sram_arb_2p.sv
// Randomized scoreboard bench for sram_arb_2p with a behavioural SRAM and reference memory.
module tb_sram_arb_2p;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int WORDS = 8192;

  typedef struct {
    logic          rd;
    logic [DW-1:0] data;
  } rsp_t;

  logic clk, rst_n;
  logic          r   [2];
  logic [AW+1:0] a   [2];
  logic          we  [2];
  logic [BW-1:0] be  [2];
  logic [DW-1:0] wd  [2];

  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          sram_cen_n, sram_gwen_n;
  logic [BW-1:0] sram_ben_n;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d, sram_q;

  logic [DW-1:0] sram_mem [WORDS];
  logic [DW-1:0] ref_mem  [WORDS];
  rsp_t q0 [$];
  rsp_t q1 [$];
  int checks = 0;
  int errors = 0;
  int m_last;
  logic gl [2];

  sram_arb_2p dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p0_req_i     (r[0]),
    .p0_addr_i    (a[0]),
    .p0_we_i      (we[0]),
    .p0_be_i      (be[0]),
    .p0_wdata_i   (wd[0]),
    .p0_gnt_o     (p0_gnt),
    .p0_rvalid_o  (p0_rvalid),
    .p0_rdata_o   (p0_rdata),
    .p1_req_i     (r[1]),
    .p1_addr_i    (a[1]),
    .p1_we_i      (we[1]),
    .p1_be_i      (be[1]),
    .p1_wdata_i   (wd[1]),
    .p1_gnt_o     (p1_gnt),
    .p1_rvalid_o  (p1_rvalid),
    .p1_rdata_o   (p1_rdata),
    .sram_cen_n_o (sram_cen_n),
    .sram_gwen_n_o(sram_gwen_n),
    .sram_ben_n_o (sram_ben_n),
    .sram_a_o     (sram_a),
    .sram_d_o     (sram_d),
    .sram_q_i     (sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM macro: active-low controls, registered read data.
  always @(posedge clk) begin
    if (!sram_cen_n) begin
      if (!sram_gwen_n) begin
        for (int b = 0; b < BW; b++)
          if (!sram_ben_n[b]) sram_mem[sram_a][8*b +: 8] <= sram_d[8*b +: 8];
      end else begin
        sram_q <= sram_mem[sram_a];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_port(input int n, input logic rv, input logic [DW-1:0] rd);
    rsp_t e;
    if (rv) begin
      checks++;
      if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
        errors++;
        $display("FAIL p%0d_unexpected_rvalid actual=1 expected=0 at %0t", n, $time);
      end else begin
        e = (n == 0) ? q0.pop_front() : q1.pop_front();
        if (e.rd) chk($sformatf("p%0d_rdata", n), {32'd0, rd}, {32'd0, e.data});
      end
    end else begin
      chk($sformatf("p%0d_rdata_gated", n), {32'd0, rd}, 64'd0);
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon_port(0, p0_rvalid, p0_rdata);
    mon_port(1, p1_rvalid, p1_rdata);
  end

  // Called with inputs settled mid-cycle: checks grant and SRAM pins, records expectations.
  task automatic check_and_push();
    int win;
    rsp_t e;
    logic [AW-1:0] w;
    logic [50:0] exp_pins;
    #1;
    if (r[0] && r[1]) win = 1 - m_last;
    else if (r[0]) win = 0;
    else if (r[1]) win = 1;
    else win = -1;
    chk("gnt", {62'd0, p1_gnt, p0_gnt},
        {62'd0, (win == 1) ? 1'b1 : 1'b0, (win == 0) ? 1'b1 : 1'b0});
    if (win < 0) begin
      exp_pins = {1'b1, 1'b1, 4'hF, 13'd0, 32'd0};
    end else begin
      w = a[win][AW+1:2];
      exp_pins = {1'b0, ~we[win], we[win] ? ~be[win] : 4'hF, w, wd[win]};
      e.rd = ~we[win];
      e.data = ref_mem[w];
      if (we[win])
        for (int b = 0; b < BW; b++)
          if (be[win][b]) ref_mem[w][8*b +: 8] = wd[win][8*b +: 8];
      if (win == 0) q0.push_back(e);
      else q1.push_back(e);
      m_last = win;
    end
    chk("sram_pins", {13'd0, sram_cen_n, sram_gwen_n, sram_ben_n, sram_a, sram_d},
        {13'd0, exp_pins});
    gl[0] = (win == 0);
    gl[1] = (win == 1);
  endtask

  task automatic drive_cycle();
    check_and_push();
    @(negedge clk);
  endtask

  task automatic set_port(input int n, input logic rq, input logic [AW+1:0] ad, input logic w,
                          input logic [BW-1:0] b, input logic [DW-1:0] d);
    r[n] = rq; a[n] = ad; we[n] = w; be[n] = b; wd[n] = d;
  endtask

  task automatic idle_ports();
    set_port(0, 1'b0, '0, 1'b0, '0, '0);
    set_port(1, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    idle_ports();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    m_last = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < WORDS; i++) begin
      v = $urandom;
      sram_mem[i] = v;
      ref_mem[i] = v;
    end
    sram_mem[2] = 32'h1122_3344;
    ref_mem[2]  = 32'h1122_3344;
    sram_q = '0;
    gl[0] = 1'b0;
    gl[1] = 1'b0;
    rst_n = 1'b1;
    idle_ports();
    @(negedge clk);
    do_reset();

    chk("reset_outputs", {p1_rvalid, p0_rvalid, p0_rdata[31:0], p1_rdata[30:0]}, 64'd0);

    // Single p0 read; response on p0 only in the next cycle.
    set_port(0, 1'b1, 15'h0010, 1'b0, 4'h0, 32'h0);
    drive_cycle();
    idle_ports();
    chk("first_read_rvalid", {62'd0, p1_rvalid, p0_rvalid}, 64'd1);
    drive_cycle();

    // Partial-byte write over 0x11223344, then read back.
    set_port(1, 1'b1, 15'h0008, 1'b1, 4'b0101, 32'hAABB_CCDD);
    drive_cycle();
    set_port(1, 1'b1, 15'h0008, 1'b0, 4'h0, 32'h0);
    drive_cycle();
    idle_ports();
    chk("partial_write_readback", {32'd0, p1_rdata}, {32'd0, 32'h11BB_33DD});
    drive_cycle();

    // Continuous contention right after reset alternates p0, p1, ...
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_port(0, 1'b1, 15'(4 * i), 1'b0, 4'h0, 32'h0);
      set_port(1, 1'b1, 15'(4 * i + 64), 1'b0, 4'h0, 32'h0);
      if (i > 0) chk("alternate", {63'd0, gl[0]}, {63'd0, i[0]});
      check_and_push();
      @(negedge clk);
    end
    idle_ports();
    drive_cycle();

    // Pipelined burst of reads from a sole requester.
    for (int i = 0; i < 4; i++) begin
      set_port(0, 1'b1, 15'(4 * i), 1'b0, 4'h0, 32'h0);
      drive_cycle();
    end
    idle_ports();
    drive_cycle();
    drive_cycle();

    // Reset right after a p1 grant drops its response.
    set_port(1, 1'b1, 15'h0020, 1'b0, 4'h0, 32'h0);
    check_and_push();
    q1.delete();
    @(posedge clk);
    rst_n = 1'b0;
    idle_ports();
    m_last = 1;
    #2;
    chk("reset_drops_rvalid", {63'd0, p1_rvalid}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_port(0, 1'b1, 15'h0004, 1'b1, 4'hF, 32'hDEAD_BEEF);
    set_port(1, 1'b1, 15'h0024, 1'b1, 4'h3, 32'h1234_5678);
    drive_cycle();
    chk("post_reset_p0_wins", {63'd0, gl[0]}, 64'd1);

    // Random traffic with held requests, occasional drops and aliased addresses.
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (r[n] && !gl[n]) begin
          if ($urandom_range(15) == 0) r[n] = 1'b0;
        end else if ($urandom_range(9) < 6) begin
          set_port(n, 1'b1, 15'($urandom), 1'($urandom), 4'($urandom), $urandom);
        end else begin
          r[n] = 1'b0;
        end
      end
      drive_cycle();
    end
    idle_ports();
    drive_cycle();
    drive_cycle();
    chk("queues_drained", {32'(q0.size()), 32'(q1.size())}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
